// File: rtl/visor_target_debug_if.sv
// Visor register-space bus for visor_target_debug.
// The visor MCU drives write strobes into the adapter and reads back its
// debug registers over this interface.
//   wr_en / wr_sel / wr_data : register write port (visor -> adapter)
//   bp_addr_rd               : {bp3,bp2,bp1,bp0} breakpoint read-back
//   bp_status                : per-slot hit flags
//   exr_shadow               : target EXR captured at the hit
//   peek_data / peek_valid   : last target debug peek write and freshness flag
//   bp_hit_count             : hit counter, present only with VISOR_BP_HIT_COUNT_EN
// Optional feature macro: VISOR_BP_HIT_COUNT_EN
interface visor_target_debug_if;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic [63:0] bp_addr_rd;
    logic [3:0]  bp_status;
    logic [15:0] exr_shadow;
    logic [15:0] peek_data;
    logic        peek_valid;
`ifdef VISOR_BP_HIT_COUNT_EN
    logic [15:0] bp_hit_count;

    modport master (
        output wr_en, wr_sel, wr_data,
        input  bp_addr_rd, bp_status, exr_shadow, peek_data, peek_valid, bp_hit_count
    );

    modport slave (
        input  wr_en, wr_sel, wr_data,
        output bp_addr_rd, bp_status, exr_shadow, peek_data, peek_valid, bp_hit_count
    );
`else
    modport master (
        output wr_en, wr_sel, wr_data,
        input  bp_addr_rd, bp_status, exr_shadow, peek_data, peek_valid
    );

    modport slave (
        input  wr_en, wr_sel, wr_data,
        output bp_addr_rd, bp_status, exr_shadow, peek_data, peek_valid
    );
`endif
endinterface

// File: rtl/visor_target_debug.sv
// visor_target_debug: supervisor-side debug adapter between the visor MCU's
// I/O register space and the debugged target core. It watches target fetches
// for breakpoint hits, holds the target, can divert the target code bus to a
// forced opcode, issues load-EXR / execute strobes and captures peek writes.
// Ports:
//   clk, reset      : common clock, asynchronous active-low reset
//   bus (slave)     : visor register bus (see visor_target_debug_if)
//   tg_fetch, tg_code_addr, tg_code_rom, tg_exr, tg_peek_we, tg_peek_wdata :
//                     target observation inputs
//   tg_code, tg_reset, tg_hold, tg_load_exr, tg_exec : target control outputs
// Register select: 0-3 bp0..bp3, 4 bus_ctrl, 5 tg_force, 6 force_opcode,
//   7 hit counter clear (only with the optional counter).
// Optional feature macro: VISOR_BP_HIT_COUNT_EN adds bus.bp_hit_count.
module visor_target_debug #(
    parameter logic [15:0] BP_DISABLE     = 16'hffff,
    parameter logic [2:0]  RESET_BUS_CTRL = 3'b010
) (
    input  logic                 clk,
    input  logic                 reset,
    visor_target_debug_if.slave  bus,
    input  logic                 tg_fetch,
    input  logic [15:0]          tg_code_addr,
    input  logic [15:0]          tg_code_rom,
    input  logic [15:0]          tg_exr,
    input  logic                 tg_peek_we,
    input  logic [15:0]          tg_peek_wdata,
    output logic [15:0]          tg_code,
    output logic                 tg_reset,
    output logic                 tg_hold,
    output logic                 tg_load_exr,
    output logic                 tg_exec
);

    typedef enum logic [1:0] {RUN, HALTED, FORCED} dbg_state_t;

    logic [3:0][15:0] bp_q;
    logic [2:0]       bus_ctrl_q;
    logic             hold_q;
    logic [15:0]      force_opcode_q;
    logic [3:0]       status_q;
    logic [3:0]       skip_q;
    logic             halted_q;
    logic [15:0]      exr_q;
    logic [15:0]      peek_q;
    logic             peek_valid_q;
    logic             load_exr_q;
    logic             exec_q;
    dbg_state_t       state_q;
    dbg_state_t       state_d;

    logic [3:0] wr_bp;
    logic [3:0] hit;
    logic [3:0] status_d;
    logic [3:0] skip_d;
    logic       wr_bus_ctrl;
    logic       wr_force;
    logic       wr_opcode;
    logic       any_hit;

    assign wr_bus_ctrl = bus.wr_en && (bus.wr_sel == 3'd4);
    assign wr_force    = bus.wr_en && (bus.wr_sel == 3'd5);
    assign wr_opcode   = bus.wr_en && (bus.wr_sel == 3'd6);
    assign any_hit     = |hit;

    assign tg_reset    = bus_ctrl_q[1];
    assign tg_hold     = halted_q | hold_q | tg_reset;
    assign tg_code     = bus_ctrl_q[2] ? force_opcode_q : tg_code_rom;
    assign tg_load_exr = load_exr_q;
    assign tg_exec     = exec_q;

    assign bus.bp_addr_rd = {bp_q[3], bp_q[2], bp_q[1], bp_q[0]};
    assign bus.bp_status  = status_q;
    assign bus.exr_shadow = exr_q;
    assign bus.peek_data  = peek_q;
    assign bus.peek_valid = peek_valid_q;

    // Per-slot breakpoint match. A write to a slot beats a match in the same
    // cycle and arms its skip flag, so rewriting the address the target is
    // parked on lets it step past once before the slot can fire again.
    always_comb begin
        wr_bp    = '0;
        hit      = '0;
        status_d = status_q;
        skip_d   = skip_q;
        for (int i = 0; i < 4; i++) begin
            wr_bp[i] = bus.wr_en && (bus.wr_sel == 3'(i));
            hit[i]   = tg_fetch && !tg_hold && (tg_code_addr == bp_q[i]) &&
                       (bp_q[i] != BP_DISABLE) && !skip_q[i] && !wr_bp[i];
            if (wr_bp[i]) begin
                status_d[i] = 1'b0;
                skip_d[i]   = 1'b1;
            end else begin
                status_d[i] = status_q[i] | hit[i];
                if (tg_fetch && (tg_code_addr != bp_q[i])) begin
                    skip_d[i] = 1'b0;
                end
            end
        end
    end

    // Visor-visible registers, breakpoint bookkeeping and target strobes.
    // The load/exec strobes only fire if the target is already held when the
    // visor writes tg_force; bit0 is the only stored tg_force bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bp_q           <= {4{BP_DISABLE}};
            bus_ctrl_q     <= RESET_BUS_CTRL;
            hold_q         <= 1'b0;
            force_opcode_q <= '0;
            status_q       <= '0;
            skip_q         <= '0;
            halted_q       <= 1'b0;
            exr_q          <= '0;
            peek_q         <= '0;
            peek_valid_q   <= 1'b0;
            load_exr_q     <= 1'b0;
            exec_q         <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_bp[i]) begin
                    bp_q[i] <= bus.wr_data;
                end
            end
            status_q <= status_d;
            skip_q   <= skip_d;
            halted_q <= any_hit | (halted_q & (|status_d));
            if (any_hit) begin
                exr_q <= tg_exr;
            end
            if (wr_bus_ctrl) begin
                bus_ctrl_q <= bus.wr_data[2:0];
            end
            if (wr_opcode) begin
                force_opcode_q <= bus.wr_data;
            end
            if (wr_force) begin
                hold_q <= bus.wr_data[0];
            end
            load_exr_q <= wr_force && bus.wr_data[1] && tg_hold;
            exec_q     <= wr_force && bus.wr_data[2] && tg_hold;
            if (tg_peek_we) begin
                peek_q       <= tg_peek_wdata;
                peek_valid_q <= 1'b1;
            end else if (wr_force && bus.wr_data[2]) begin
                peek_valid_q <= 1'b0;
            end
        end
    end

    // Debug state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Debug state sequencing: a held tg_force[0] overrides everything, and on
    // release the target goes back to halted only while some hit is pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (hold_q) begin
                    state_d = FORCED;
                end else if (any_hit) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (hold_q) begin
                    state_d = FORCED;
                end else if (status_d == 4'b0000) begin
                    state_d = RUN;
                end
            end
            FORCED: begin
                if (!hold_q) begin
                    state_d = (status_d != 4'b0000) ? HALTED : RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`ifdef VISOR_BP_HIT_COUNT_EN
    logic [15:0] hit_count_q;

    // Counts hit events, not slots: simultaneous hits add one. Sticks at max.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count_q <= '0;
        end else if (bus.wr_en && (bus.wr_sel == 3'd7)) begin
            hit_count_q <= '0;
        end else if (any_hit && (hit_count_q != 16'hffff)) begin
            hit_count_q <= hit_count_q + 16'd1;
        end
    end

    assign bus.bp_hit_count = hit_count_q;
`else
    // Without the counter, register select 7 has no destination.
`endif

endmodule

// File: tb/tb_visor_target_debug.sv
// Self-checking bench for visor_target_debug: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// adapter's register and breakpoint rules.
module tb_visor_target_debug;

    logic        clk = 1'b0;
    logic        reset;
    logic        tg_fetch, tg_peek_we;
    logic [15:0] tg_code_addr, tg_code_rom, tg_exr, tg_peek_wdata;
    logic [15:0] tg_code;
    logic        tg_reset, tg_hold, tg_load_exr, tg_exec;

    int checks = 0;
    int errors = 0;

    visor_target_debug_if vif();

    visor_target_debug dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (vif),
        .tg_fetch      (tg_fetch),
        .tg_code_addr  (tg_code_addr),
        .tg_code_rom   (tg_code_rom),
        .tg_exr        (tg_exr),
        .tg_peek_we    (tg_peek_we),
        .tg_peek_wdata (tg_peek_wdata),
        .tg_code       (tg_code),
        .tg_reset      (tg_reset),
        .tg_hold       (tg_hold),
        .tg_load_exr   (tg_load_exr),
        .tg_exec       (tg_exec)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_bp [4];
    logic [3:0]  m_status, m_skip;
    logic        m_halted, m_hold_bit, m_load, m_exec, m_pvalid;
    logic [2:0]  m_bus;
    logic [15:0] m_opcode, m_exr, m_peek, m_count;

    function automatic logic m_hold();
        return m_halted | m_hold_bit | m_bus[1];
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) m_bp[n] = 16'hffff;
        m_status = 0; m_skip = 0; m_halted = 0; m_hold_bit = 0;
        m_load = 0; m_exec = 0; m_pvalid = 0; m_bus = 3'b010;
        m_opcode = 0; m_exr = 0; m_peek = 0; m_count = 0;
    endtask

    // One clock of the rules, using the inputs currently applied.
    task automatic model_clock();
        logic       h;
        logic [3:0] hits;
        logic       wr_this;
        logic       fw;
        h = m_hold();
        hits = 0;
        for (int n = 0; n < 4; n++) begin
            wr_this = vif.wr_en && (vif.wr_sel == 3'(n));
            hits[n] = tg_fetch && !h && tg_code_addr == m_bp[n] &&
                      m_bp[n] != 16'hffff && !m_skip[n] && !wr_this;
            if (wr_this) begin
                m_bp[n] = vif.wr_data;
                m_status[n] = 0;
                m_skip[n] = 1;
            end else begin
                if (hits[n]) m_status[n] = 1;
                if (tg_fetch && tg_code_addr != m_bp[n]) m_skip[n] = 0;
            end
        end
        m_halted = (hits != 0) || (m_halted && m_status != 0);
        if (hits != 0) m_exr = tg_exr;
        fw = vif.wr_en && vif.wr_sel == 3'd5;
        m_load = fw && vif.wr_data[1] && h;
        m_exec = fw && vif.wr_data[2] && h;
        if (fw) m_hold_bit = vif.wr_data[0];
        if (vif.wr_en && vif.wr_sel == 3'd4) m_bus = vif.wr_data[2:0];
        if (vif.wr_en && vif.wr_sel == 3'd6) m_opcode = vif.wr_data;
        if (tg_peek_we) begin
            m_peek = tg_peek_wdata;
            m_pvalid = 1;
        end else if (fw && vif.wr_data[2]) begin
            m_pvalid = 0;
        end
        if (vif.wr_en && vif.wr_sel == 3'd7) m_count = 0;
        else if (hits != 0 && m_count != 16'hffff) m_count = m_count + 1;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vif.wr_en = 0; tg_fetch = 0; tg_peek_we = 0;
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [15:0] data);
        vif.wr_en = 1; vif.wr_sel = sel; vif.wr_data = data;
        tick();
        vif.wr_en = 0;
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [15:0] exr);
        tg_fetch = 1; tg_code_addr = addr; tg_exr = exr;
        tick();
        tg_fetch = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        idle();
        vif.wr_sel = 0; vif.wr_data = 0;
        tg_code_addr = 0; tg_code_rom = 16'h1234; tg_exr = 0; tg_peek_wdata = 0;
        model_reset();
        #12;
        checks++; if (tg_reset !== 1'b1) begin errors++; $display("FAIL reset_tg_reset got %b want 1", tg_reset); end
        checks++; if (tg_hold !== 1'b1) begin errors++; $display("FAIL reset_tg_hold got %b want 1", tg_hold); end
        checks++; if (vif.bp_addr_rd !== {4{16'hffff}}) begin errors++; $display("FAIL reset_bp got %h want all ffff", vif.bp_addr_rd); end
        checks++; if (vif.bp_status !== 4'b0 || vif.peek_valid !== 1'b0 || tg_load_exr !== 1'b0 || tg_exec !== 1'b0) begin
            errors++; $display("FAIL reset_flags got status %b pv %b ld %b ex %b want 0", vif.bp_status, vif.peek_valid, tg_load_exr, tg_exec);
        end
        reset = 1;
        tick();
    endtask

    task automatic test_release();
        write_reg(3'd4, 16'h0000);
        checks++; if (tg_reset !== 1'b0) begin errors++; $display("FAIL release_tg_reset got %b want 0", tg_reset); end
        checks++; if (tg_hold !== 1'b0) begin errors++; $display("FAIL release_tg_hold got %b want 0", tg_hold); end
        fetch(16'hffff, 16'h0001);
        checks++; if (vif.bp_status !== 4'b0000 || tg_hold !== 1'b0) begin
            errors++; $display("FAIL disabled_no_hit got status %b hold %b want 0000 0", vif.bp_status, tg_hold);
        end
    endtask

    task automatic test_breakpoint();
        write_reg(3'd0, 16'h0015);
        fetch(16'h0014, 16'h0000);
        fetch(16'h0015, 16'h7c07);
        checks++; if (vif.bp_status !== 4'b0001) begin errors++; $display("FAIL bp0_status got %b want 0001", vif.bp_status); end
        checks++; if (tg_hold !== 1'b1) begin errors++; $display("FAIL bp0_hold got %b want 1", tg_hold); end
        checks++; if (vif.exr_shadow !== 16'h7c07) begin errors++; $display("FAIL bp0_exr got %h want 7c07", vif.exr_shadow); end
    endtask

    task automatic test_force();
        write_reg(3'd4, 16'h0004);
        write_reg(3'd6, 16'h7c07);
        checks++; if (tg_code !== 16'h7c07) begin errors++; $display("FAIL divert_code got %h want 7c07", tg_code); end
        write_reg(3'd5, 16'h0003);
        checks++; if (tg_load_exr !== 1'b1 || tg_exec !== 1'b0) begin
            errors++; $display("FAIL load_pulse got ld %b ex %b want 1 0", tg_load_exr, tg_exec);
        end
        tick();
        checks++; if (tg_load_exr !== 1'b0) begin errors++; $display("FAIL load_pulse_width got %b want 0", tg_load_exr); end
        write_reg(3'd5, 16'h0005);
        checks++; if (tg_exec !== 1'b1 || tg_load_exr !== 1'b0) begin
            errors++; $display("FAIL exec_pulse got ex %b ld %b want 1 0", tg_exec, tg_load_exr);
        end
        tg_peek_we = 1; tg_peek_wdata = 16'hbeef;
        tick();
        tg_peek_we = 0;
        checks++; if (tg_exec !== 1'b0) begin errors++; $display("FAIL exec_pulse_width got %b want 0", tg_exec); end
        checks++; if (vif.peek_data !== 16'hbeef || vif.peek_valid !== 1'b1) begin
            errors++; $display("FAIL peek got %h v%b want beef v1", vif.peek_data, vif.peek_valid);
        end
    endtask

    task automatic test_pass_once();
        write_reg(3'd5, 16'h0000);
        write_reg(3'd4, 16'h0000);
        write_reg(3'd0, 16'h0015);
        checks++; if (vif.bp_status !== 4'b0000 || tg_hold !== 1'b0) begin
            errors++; $display("FAIL rewrite_clear got status %b hold %b want 0000 0", vif.bp_status, tg_hold);
        end
        fetch(16'h0015, 16'h2222);
        checks++; if (vif.bp_status !== 4'b0000) begin errors++; $display("FAIL pass_once got %b want 0000", vif.bp_status); end
        fetch(16'h0016, 16'h2222);
        fetch(16'h0015, 16'h1111);
        checks++; if (vif.bp_status !== 4'b0001 || vif.exr_shadow !== 16'h1111) begin
            errors++; $display("FAIL rehit got status %b exr %h want 0001 1111", vif.bp_status, vif.exr_shadow);
        end
    endtask

    task automatic test_back_to_back();
        write_reg(3'd0, 16'hffff);
        write_reg(3'd2, 16'h0030);
        fetch(16'h0031, 16'h0000);
        vif.wr_en = 1; vif.wr_sel = 3'd2; vif.wr_data = 16'h0030;
        tg_fetch = 1; tg_code_addr = 16'h0030; tg_exr = 16'h3333;
        tick();
        idle();
        checks++; if (vif.bp_status !== 4'b0000 || tg_hold !== 1'b0) begin
            errors++; $display("FAIL write_wins got status %b hold %b want 0000 0", vif.bp_status, tg_hold);
        end
        fetch(16'h0031, 16'h0000);
        fetch(16'h0030, 16'h4444);
        checks++; if (vif.bp_status !== 4'b0100 || vif.exr_shadow !== 16'h4444) begin
            errors++; $display("FAIL bp2_hit got status %b exr %h want 0100 4444", vif.bp_status, vif.exr_shadow);
        end
    endtask

    task automatic test_async_reset();
        write_reg(3'd4, 16'h0004);
        tg_code_rom = 16'h1234;
        checks++; if (tg_code !== m_opcode) begin errors++; $display("FAIL pre_reset_divert got %h want %h", tg_code, m_opcode); end
        #3;
        reset = 0;
        model_reset();
        #1;
        checks++; if (tg_code !== 16'h1234 || tg_reset !== 1'b1 || tg_hold !== 1'b1) begin
            errors++; $display("FAIL async_reset_tg got code %h rst %b hold %b want 1234 1 1", tg_code, tg_reset, tg_hold);
        end
        checks++; if (vif.bp_status !== 4'b0 || vif.exr_shadow !== 16'h0 || vif.peek_data !== 16'h0 || vif.peek_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_regs got st %b exr %h pk %h v %b want zeros", vif.bp_status, vif.exr_shadow, vif.peek_data, vif.peek_valid);
        end
        checks++; if (vif.bp_addr_rd !== {4{16'hffff}}) begin errors++; $display("FAIL async_reset_bp got %h want all ffff", vif.bp_addr_rd); end
        #2;
        reset = 1;
        tick();
    endtask

    function automatic logic [15:0] pool_addr();
        case ($urandom_range(0, 4))
            0: return 16'h0040;
            1: return 16'h0041;
            2: return 16'h0042;
            3: return 16'h0043;
            default: return 16'hffff;
        endcase
    endfunction

    task automatic test_random();
        logic [15:0] d;
        for (int c = 0; c < 600; c++) begin
            vif.wr_en = ($urandom_range(0, 3) == 0);
            vif.wr_sel = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            if (vif.wr_sel < 3'd4) d = pool_addr();
            if (vif.wr_sel == 3'd4) d = (d & 16'hfffd) | (($urandom_range(0, 7) == 0) ? 16'h0002 : 16'h0000);
            if (vif.wr_sel == 3'd5 && $urandom_range(0, 1) == 0) d[0] = 1'b0;
            vif.wr_data = d;
            tg_fetch = ($urandom_range(0, 1) == 1);
            tg_code_addr = pool_addr();
            tg_exr = 16'($urandom);
            tg_code_rom = 16'($urandom);
            tg_peek_we = ($urandom_range(0, 5) == 0);
            tg_peek_wdata = 16'($urandom);
            tick();
            checks++; if (tg_code !== (m_bus[2] ? m_opcode : tg_code_rom)) begin errors++; $display("FAIL rnd_tg_code c%0d got %h", c, tg_code); end
            checks++; if (tg_reset !== m_bus[1] || tg_hold !== m_hold()) begin
                errors++; $display("FAIL rnd_reset_hold c%0d got %b%b want %b%b", c, tg_reset, tg_hold, m_bus[1], m_hold());
            end
            checks++; if (tg_load_exr !== m_load || tg_exec !== m_exec) begin
                errors++; $display("FAIL rnd_strobes c%0d got %b%b want %b%b", c, tg_load_exr, tg_exec, m_load, m_exec);
            end
            checks++; if (vif.bp_status !== m_status) begin errors++; $display("FAIL rnd_status c%0d got %b want %b", c, vif.bp_status, m_status); end
            checks++; if (vif.exr_shadow !== m_exr) begin errors++; $display("FAIL rnd_exr c%0d got %h want %h", c, vif.exr_shadow, m_exr); end
            checks++; if (vif.peek_data !== m_peek || vif.peek_valid !== m_pvalid) begin
                errors++; $display("FAIL rnd_peek c%0d got %h %b want %h %b", c, vif.peek_data, vif.peek_valid, m_peek, m_pvalid);
            end
            checks++; if (vif.bp_addr_rd !== {m_bp[3], m_bp[2], m_bp[1], m_bp[0]}) begin
                errors++; $display("FAIL rnd_bp c%0d got %h", c, vif.bp_addr_rd);
            end
`ifdef VISOR_BP_HIT_COUNT_EN
            checks++; if (vif.bp_hit_count !== m_count) begin errors++; $display("FAIL rnd_count c%0d got %h want %h", c, vif.bp_hit_count, m_count); end
`endif
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_release();
        test_breakpoint();
        test_force();
        test_pass_once();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/visor_target_debug.md
Name: visor_target_debug

Overview:
- Supervisor-side debug adapter between the visor MCU's I/O register space and the debugged target core.
- The visor program writes breakpoint addresses, `bus_ctrl`, `tg_force` and `force_opcode` into this block, and reads `bp_status`, `exr_shadow` and `peek_data` back from it.
- Target side: it watches target fetches for breakpoint hits and holds the target's state machine.
- It diverts the target code bus to a forced opcode, issues single-cycle load-EXR/execute strobes, and captures the target's debug peek writes.

Parameters:
- `BP_DISABLE`, 16'hffff, breakpoint address value meaning "slot disabled"; never matches.
- `RESET_BUS_CTRL`, 3'b010, reset value of `bus_ctrl`; the target is held in reset until the visor releases it.

Ports:
- `clk`  in  1  visor/target common clock
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  visor register write strobe
- `wr_sel`  in  3  0-3 = bp0..bp3_addr, 4 = bus_ctrl, 5 = tg_force, 6 = force_opcode, 7 = ignored
- `wr_data`  in  16  write data
- `bp_addr_rd`  out  64  {bp3,bp2,bp1,bp0} current breakpoint registers, for visor read-back
- `bp_status`  out  4  per-slot hit flags
- `exr_shadow`  out  16  target EXR captured at hit
- `peek_data`  out  16  last target debug_peek_reg write
- `peek_valid`  out  1  `peek_data` fresh since last force_exec
- `tg_fetch`  in  1  target performs an instruction fetch this cycle
- `tg_code_addr`  in  16  target fetch address
- `tg_code_rom`  in  16  target program ROM content
- `tg_exr`  in  16  target EXR contents
- `tg_peek_we`  in  1  target executing debug_peek_reg write
- `tg_peek_wdata`  in  16  that write's data
- `tg_code`  out  16  code word presented to target
- `tg_reset`  out  1  target reset (active high)
- `tg_hold`  out  1  freeze target state machine
- `tg_load_exr`  out  1  one-cycle strobe: target loads EXR from `tg_code`
- `tg_exec`  out  1  one-cycle strobe: target executes EXR while held

Behaviour:
Register field layout:
- `bus_ctrl`: bit1 = tg_reset, bit2 = divert_code_bus.
- `tg_force`: bit0 = hold_state, bit1 = force_load_exr, bit2 = force_exec.

Reset values (async on reset low):
- bp0..3 = `BP_DISABLE`; `bus_ctrl` = `RESET_BUS_CTRL`; `tg_force` = 0; `force_opcode` = 0.
- `bp_status` = 0; skip flags = 0; halted = 0.
- `exr_shadow` = 0; `peek_data` = 0; `peek_valid` = 0.
- `tg_load_exr` = 0; `tg_exec` = 0.

Outputs:
- `tg_code` is combinational: `bus_ctrl[2]` ? `force_opcode` : `tg_code_rom`.
- `tg_reset` = `bus_ctrl[1]`.
- `tg_hold` = halted | `tg_force[0]` | `tg_reset`.

Breakpoint match, slot N, evaluated in cycle t:
- Hit condition: `tg_fetch` & !`tg_hold` & `tg_code_addr`==bpN & bpN!=`BP_DISABLE` & !skipN.
- At t+1: `bp_status[N]`=1, halted=1, `exr_shadow` <= `tg_exr` sampled at t.
- Multiple slots hitting in the same cycle set all of their status bits.

Write to bpN:
- Loads the address, clears `bp_status[N]`, sets skipN.
- This gives pass-once semantics when rewriting the same address.
- skipN clears on any `tg_fetch` with `tg_code_addr` != bpN.
- halted clears at t+1 when `bp_status` becomes all-zero.
- A write to bpN in the same cycle as a bpN match wins: no hit is recorded, and skip is set.

Write to `tg_force`:
- Register stores bit0 only.
- Bits 1 and 2 each produce exactly one-cycle pulses on `tg_load_exr` / `tg_exec` in the cycle after the write.
- Pulses are suppressed unless `tg_hold` is high at the write cycle.

Debug peek:
- `tg_peek_we` captures `tg_peek_wdata` into `peek_data` and sets `peek_valid` next cycle.
- A force_exec write clears `peek_valid`.
- A simultaneous `tg_peek_we` sets `peek_valid`.

State machine `{RUN, HALTED, FORCED}`:
- RUN -> HALTED on hit.
- HALTED/RUN -> FORCED while `tg_force[0]`=1.
- FORCED -> HALTED when `tg_force[0]`=0 and status is nonzero; otherwise -> RUN.
- Any state -> RUN on reset.

Optional Feature:
- Macro: `VISOR_BP_HIT_COUNT_EN`.
- When defined: adds output `bp_hit_count [15:0]`.
  - Increments once per recorded hit; simultaneous multi-slot hits count 1.
  - Saturates at 16'hffff.
  - Cleared by reset or by a write with `wr_sel`=7.
- When undefined: no port or counter is present, and `wr_sel`=7 is ignored.

Test Plan:
- Release reset: `tg_reset`=1, `tg_hold`=1, all bp = ffff. Write `bus_ctrl`=0 -> `tg_reset`=0 and `tg_hold`=0 next cycle; a fetch at 0xffff produces no hit.
- Write bp0=0x0015, target fetches 0x0015 with `tg_exr`=0x7c07 -> next cycle `bp_status`=4'b0001, `tg_hold`=1, `exr_shadow`=0x7c07.
- While halted: write `bus_ctrl`=4, `force_opcode`=0x7c07, `tg_force`=3 then 5. Target peek write 0xbeef -> `tg_code`=0x7c07, one `tg_load_exr` pulse, one `tg_exec` pulse, `peek_data`=0xbeef, `peek_valid`=1.
- Rewrite bp0=0x0015 with `tg_force`=0 and `bus_ctrl`=0 -> status clears, target refetches 0x0015 with no hit. It advances to 0x0016, then a later fetch of 0x0015 hits again.
- Write bp2=0x0030 in the same cycle as a fetch of 0x0030 -> no hit, `bp_status`=0. The next fetch of 0x0031 followed by 0x0030 hits.
- Assert reset mid-halt with divert active -> all outputs return to reset values asynchronously.
